// File: rtl/decode_branch_pkg.sv
// decode_branch_pkg: shared RV32I decode types, opcode and funct3 constants for the ID stage
package decode_branch_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0] reg_idx_t;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     is_load;
    } sb_entry_t;
    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;
    function automatic logic sb_hit(input sb_entry_t e, input reg_idx_t rs, input logic used);
        return used && e.valid && (e.rd != '0) && (e.rd == rs);
    endfunction
endpackage

// File: rtl/decode_branch_imm_gen.sv
// decode_branch_imm_gen: RV32I immediate extraction for every format plus the format the opcode uses
module decode_branch_imm_gen
    import decode_branch_pkg::*;
(
    input  word_t    i_instr,
    output word_t    o_imm_i,
    output word_t    o_imm_s,
    output word_t    o_imm_b,
    output word_t    o_imm_u,
    output word_t    o_imm_j,
    output imm_fmt_t o_fmt
);
    logic [6:0] w_op;
    assign w_op    = i_instr[6:0];
    assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign o_imm_u = {i_instr[31:12], 12'h000};
    assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    always_comb begin
        o_fmt = (w_op == OP_JAL)                          ? FMT_J
              : (w_op == OP_BRANCH)                       ? FMT_B
              : (w_op == OP_STORE)                        ? FMT_S
              : (w_op inside {OP_LUI, OP_AUIPC})          ? FMT_U
              : (w_op inside {OP_IMM, OP_LOAD, OP_JALR})  ? FMT_I
              : FMT_NONE;
    end
endmodule

// File: rtl/decode_branch.sv
// decode_branch: RV32I decode stage with in-ID branch resolution, scoreboard hazard stalls and ID/EX register
module decode_branch
    import decode_branch_pkg::*;
#(
    parameter bit REGFILE_BYPASS = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  word_t    pc_in,
    input  word_t    instr_in,
    output reg_idx_t rs1_addr,
    output reg_idx_t rs2_addr,
    input  word_t    rs1_data,
    input  word_t    rs2_data,
    output logic     stall_f,
    output logic     branch_taken,
    output word_t    branch_target,
    output logic     ex_valid,
    output word_t    ex_pc,
    output word_t    ex_instr,
    output word_t    ex_imm,
    output word_t    ex_rs1_val,
    output word_t    ex_rs2_val,
    output reg_idx_t ex_rd
);
    localparam int SB_DEPTH = REGFILE_BYPASS ? 2 : 3;
    logic [6:0] w_op;
    logic [2:0] w_f3;
    word_t      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm, w_jalr_sum, w_tgt;
    imm_fmt_t   w_fmt;
    logic       w_use1, w_use2, w_is_br, w_is_jal, w_is_jalr, w_has_rd;
    logic       w_hazard, w_cond, w_taken;
    reg_idx_t   w_rd;
    sb_entry_t  w_sb_in;
    sb_entry_t  r_sb [SB_DEPTH];
    logic       r_valid;
    word_t      r_pc, r_instr, r_imm, r_rs1, r_rs2;
    reg_idx_t   r_rd;

    decode_branch_imm_gen u_imm (
        .i_instr (instr_in),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j),
        .o_fmt   (w_fmt)
    );

    assign w_op      = instr_in[6:0];
    assign w_f3      = instr_in[14:12];
    assign rs1_addr  = instr_in[19:15];
    assign rs2_addr  = instr_in[24:20];
    assign w_is_br   = w_op == OP_BRANCH;
    assign w_is_jal  = w_op == OP_JAL;
    assign w_is_jalr = w_op == OP_JALR;
    assign w_use1    = w_op inside {OP_BRANCH, OP_JALR, OP_LOAD, OP_IMM, OP_REG, OP_STORE};
    assign w_use2    = w_op inside {OP_BRANCH, OP_REG, OP_STORE};
    assign w_has_rd  = w_op inside {OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC};
    assign w_rd      = w_has_rd ? instr_in[11:7] : '0;
    assign w_sb_in   = w_hazard ? '0 : {1'b1, w_rd, w_op == OP_LOAD};

    always_comb begin
        w_imm = (w_fmt == FMT_I) ? w_imm_i
              : (w_fmt == FMT_S) ? w_imm_s
              : (w_fmt == FMT_B) ? w_imm_b
              : (w_fmt == FMT_U) ? w_imm_u
              : (w_fmt == FMT_J) ? w_imm_j
              : '0;
    end

    // Control transfers read operands in ID, so any in-flight producer stalls them; others only wait on a load in EX.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < SB_DEPTH; k++)
            if ((w_is_br || w_is_jalr || (k == 0 && r_sb[k].is_load)) &&
                (sb_hit(r_sb[k], rs1_addr, w_use1) || sb_hit(r_sb[k], rs2_addr, w_use2)))
                w_hazard = 1'b1;
    end

    always_comb begin
        w_cond = (w_f3 == F3_BEQ)  ? (rs1_data == rs2_data)
               : (w_f3 == F3_BNE)  ? (rs1_data != rs2_data)
               : (w_f3 == F3_BLT)  ? ($signed(rs1_data) <  $signed(rs2_data))
               : (w_f3 == F3_BGE)  ? ($signed(rs1_data) >= $signed(rs2_data))
               : (w_f3 == F3_BLTU) ? (rs1_data <  rs2_data)
               : (w_f3 == F3_BGEU) ? (rs1_data >= rs2_data)
               : 1'b0;
    end

    assign w_taken       = !w_hazard && (w_is_jal || w_is_jalr || (w_is_br && w_cond));
    assign w_jalr_sum    = rs1_data + w_imm_i;
    assign w_tgt         = w_is_jalr ? {w_jalr_sum[31:1], 1'b0} : pc_in + (w_is_jal ? w_imm_j : w_imm_b);
    assign stall_f       = !rst && w_hazard;
    assign branch_taken  = !rst && w_taken;
    assign branch_target = rst ? '0 : w_taken ? w_tgt : pc_in + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_imm   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            for (int k = 0; k < SB_DEPTH; k++)
                r_sb[k] <= '0;
        end else begin
            r_valid <= !w_hazard;
            r_pc    <= w_hazard ? '0 : pc_in;
            r_instr <= w_hazard ? '0 : instr_in;
            r_imm   <= w_hazard ? '0 : w_imm;
            r_rs1   <= w_hazard ? '0 : rs1_data;
            r_rs2   <= w_hazard ? '0 : rs2_data;
            r_rd    <= w_hazard ? '0 : w_rd;
            r_sb[0] <= w_sb_in;
            for (int k = 1; k < SB_DEPTH; k++)
                r_sb[k] <= r_sb[k-1];
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_instr   = r_instr;
    assign ex_imm     = r_imm;
    assign ex_rs1_val = r_rs1;
    assign ex_rs2_val = r_rs2;
    assign ex_rd      = r_rd;
endmodule

// File: tb/tb_decode_branch.sv
// tb_decode_branch: randomized and directed checking of decode_branch against an instruction-history model
module tb_decode_branch;
    localparam bit BYP = 1'b1;
    localparam int D   = BYP ? 2 : 3;
    localparam logic [6:0] L_LOAD = 7'h03, L_IMM = 7'h13, L_AUIPC = 7'h17, L_STORE = 7'h23, L_REG = 7'h33;
    localparam logic [6:0] L_LUI = 7'h37, L_BR = 7'h63, L_JALR = 7'h67, L_JAL = 7'h6F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in, instr_in, rs1_data, rs2_data, branch_target;
    logic [31:0] ex_pc, ex_instr, ex_imm, ex_rs1_val, ex_rs2_val;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd;
    logic        stall_f, branch_taken, ex_valid;
    logic [31:0] rf [32];

    int          checks = 0;
    int          errors = 0;
    int          n;
    logic [31:0] m_pc, m_instr, m_imm, m_r1, m_r2;
    logic [4:0]  m_rd;
    logic        m_valid, m_all;
    int          h_rd [$];
    bit          h_ld [$];
    logic [31:0] script [$];

    decode_branch #(.REGFILE_BYPASS(BYP)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall_f(stall_f), .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_imm(ex_imm),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd)
    );

    assign rs1_data = rf[instr_in[19:15]];
    assign rs2_data = rf[instr_in[24:20]];

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] v;
        case (w[6:0])
            L_IMM, L_LOAD, L_JALR: v = $signed(w[31:20]);
            L_STORE:               v = $signed({w[31:25], w[11:7]});
            L_BR:                  v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            L_LUI, L_AUIPC:        v = {w[31:12], 12'h000};
            L_JAL:                 v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default:               v = 0;
        endcase
        return v;
    endfunction

    function automatic bit reads1(input logic [6:0] op);
        return op == L_BR || op == L_JALR || op == L_LOAD || op == L_IMM || op == L_REG || op == L_STORE;
    endfunction

    function automatic bit reads2(input logic [6:0] op);
        return op == L_BR || op == L_REG || op == L_STORE;
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op == L_JAL || op == L_JALR || op == L_LOAD || op == L_IMM || op == L_REG || op == L_LUI || op == L_AUIPC;
    endfunction

    function automatic bit br_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // h_rd[k] is the rd written by the instruction issued k+1 cycles ago (0 for a bubble)
    function automatic bit hazard(input logic [31:0] w);
        bit ctl = (w[6:0] == L_BR) || (w[6:0] == L_JALR);
        for (int k = 0; k < h_rd.size() && k < D; k++)
            if (h_rd[k] != 0 && (ctl || (k == 0 && h_ld[k])) &&
                ((reads1(w[6:0]) && h_rd[k] == int'(w[19:15])) || (reads2(w[6:0]) && h_rd[k] == int'(w[24:20]))))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = L_BR;   1: w[6:0] = L_JAL;   2: w[6:0] = L_JALR;  3: w[6:0] = L_LOAD;
            4: w[6:0] = L_IMM;  5: w[6:0] = L_REG;   6: w[6:0] = L_LUI;   7: w[6:0] = L_AUIPC;
            8: w[6:0] = L_STORE; 9: w[6:0] = L_BR;   default: w[6:0] = 7'h0B;
        endcase
        w[11:7]  = 5'($urandom_range(0, 5));
        w[19:15] = 5'($urandom_range(0, 5));
        w[24:20] = 5'($urandom_range(0, 5));
        return w;
    endfunction

    function automatic logic [31:0] next_instr();
        if (script.size() != 0) return script.pop_front();
        return rand_instr();
    endfunction

    task automatic step();
        logic [6:0]  op;
        logic [31:0] tg, imm;
        logic [4:0]  rd;
        bit          hz, tk, was_rst;
        @(negedge clk);
        op  = instr_in[6:0];
        imm = ref_imm(instr_in);
        hz  = !rst && hazard(instr_in);
        tk  = !rst && !hz && (op == L_JAL || op == L_JALR || (op == L_BR && br_cond(instr_in[14:12], rs1_data, rs2_data)));
        tg  = rst ? 32'h0 : !tk ? pc_in + 32'd4 : (op == L_JALR) ? ((rs1_data + imm) & ~32'd1) : pc_in + imm;
        chk("rs1_addr", rs1_addr, instr_in[19:15]);
        chk("rs2_addr", rs2_addr, instr_in[24:20]);
        chk("stall_f", stall_f, hz);
        chk("branch_taken", branch_taken, tk);
        chk("branch_target", branch_target, tg);
        chk("stall_taken_excl", stall_f & branch_taken, 0);
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_rd", ex_rd, m_rd);
        if (m_valid || m_all) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_instr", ex_instr, m_instr);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1_val", ex_rs1_val, m_r1);
            chk("ex_rs2_val", ex_rs2_val, m_r2);
        end
        rd = writes(op) ? instr_in[11:7] : 5'd0;
        was_rst = rst;
        if (rst) begin
            {m_valid, m_pc, m_instr, m_imm, m_r1, m_r2, m_rd} = '0;
            m_all = 1'b1;
            h_rd.delete();
            h_ld.delete();
        end else if (hz) begin
            m_valid = 1'b0;
            m_rd    = 5'd0;
            m_all   = 1'b0;
            h_rd.push_front(0);
            h_ld.push_front(1'b0);
        end else begin
            m_valid = 1'b1;
            m_all   = 1'b0;
            m_pc    = pc_in;
            m_instr = instr_in;
            m_imm   = imm;
            m_r1    = rs1_data;
            m_r2    = rs2_data;
            m_rd    = rd;
            h_rd.push_front(int'(rd));
            h_ld.push_front(op == L_LOAD);
        end
        while (h_rd.size() > 3) begin
            void'(h_rd.pop_back());
            void'(h_ld.pop_back());
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            pc_in    = 32'h0;
            instr_in = next_instr();
        end else if (!hz) begin
            pc_in    = tk ? tg : pc_in + 32'd4;
            instr_in = next_instr();
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[3] = 32'h1;
        pc_in = 32'h0;
        instr_in = 32'h00000863;
        {m_valid, m_pc, m_instr, m_imm, m_r1, m_r2, m_rd} = '0;
        m_all = 1'b1;
        script = '{32'h00500093,
                   32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
                   32'h00000013, 32'h00000013, 32'h00000013,
                   32'h00000863, 32'h00012283, 32'h00128333, 32'h0FC00067,
                   32'h00100193, 32'hFE019CE3, 32'h00000013, 32'h00C200E7, 32'h00C200E7,
                   32'h00100193, 32'h00018063, 32'h00018063};
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", stall_f, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_target", branch_target, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        rst = 1'b0;
        pc_in = 32'h0;
        instr_in = script.pop_front();
        #1;
        chk("first_ex_valid", ex_valid, 0);
        chk("first_stall", stall_f, 0);
        step();
        chk("addi_valid", ex_valid, 1);
        chk("addi_imm", ex_imm, 5);
        chk("addi_rd", ex_rd, 1);
        for (int i = 0; i < 20 && pc_in != 32'h20; i++) step();
        chk("beq_pc", pc_in, 32'h20);
        chk("beq_taken", branch_taken, 1);
        chk("beq_target", branch_target, 32'h30);
        chk("beq_stall", stall_f, 0);
        step();
        chk("beq_ex_rd", ex_rd, 0);
        chk("beq_ex_valid", ex_valid, 1);
        chk("redirect_pc", pc_in, 32'h30);
        chk("lw_stall", stall_f, 0);
        step();
        chk("load_use_stall", stall_f, 1);
        step();
        chk("load_use_bubble", ex_valid, 0);
        chk("load_use_hold_pc", pc_in, 32'h34);
        chk("load_use_release", stall_f, 0);
        step();
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd, 6);
        chk("jalr_fc_target", branch_target, 32'hFC);
        step();
        step();
        n = 0;
        for (int i = 0; i < 6 && stall_f; i++) begin
            n++;
            step();
        end
        chk("bne_stall_cycles", n, BYP ? 2 : 3);
        chk("bne_pc", pc_in, 32'h100);
        chk("bne_taken", branch_taken, 1);
        chk("bne_target", branch_target, 32'hF8);
        step();
        step();
        rf[4] = 32'h0FFFFFF7;
        #1;
        chk("jalr_taken", branch_taken, 1);
        chk("jalr_target", branch_target, 32'h10000002);
        step();
        chk("jalr_ex_rd", ex_rd, 1);
        rf[4] = 32'hFFFFFFF8;
        #1;
        chk("jalr_wrap_target", branch_target, 32'h00000004);
        step();
        step();
        chk("dep_stall", stall_f, 1);
        rst = 1'b1;
        #1;
        chk("rst_drops_stall", stall_f, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", ex_valid, 0);
        chk("post_rst_ex_pc", ex_pc, 0);
        chk("post_rst_ex_instr", ex_instr, 0);
        chk("post_rst_ex_imm", ex_imm, 0);
        chk("post_rst_ex_rd", ex_rd, 0);
        chk("post_rst_pc", pc_in, 0);
        chk("post_rst_no_stall", stall_f, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: rf[$urandom_range(1, 5)] = 32'h0;
                    1: rf[$urandom_range(1, 5)] = 32'h1;
                    2: rf[$urandom_range(1, 5)] = 32'hFFFFFFFF;
                    default: rf[$urandom_range(1, 5)] = $urandom;
                endcase
            end
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_branch.md
Name: decode_branch

Overview:
- Decode stage that consumes the fetch stage's pc/instr output and drives fetch's control inputs: stall_f, branch_taken and branch_target.
- Resolves RV32I branches and jumps in ID, so no wrong-path instruction is ever fetched.
- Generates stalls for data hazards using an internal scoreboard of the destination registers it has already issued.
- Registers the decoded instruction into the ID/EX pipeline register.

Parameters:
REGFILE_BYPASS, 1, 1 = register file is write-through, so a WB-stage producer needs no stall; 0 = a WB-stage producer also stalls (scoreboard depth 3 instead of 2).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc_in  in  32  word_t; PC of the instruction presented by fetch
instr_in  in  32  word_t; instruction word from fetch
rs1_addr  out  5  register file read address 1; combinational from instr_in
rs2_addr  out  5  register file read address 2; combinational from instr_in
rs1_data  in  32  register file read data 1; same-cycle return
rs2_data  in  32  register file read data 2; same-cycle return
stall_f  out  1  to fetch: hold pc_in/instr_in next cycle
branch_taken  out  1  to fetch: redirect this cycle
branch_target  out  32  word_t; redirect address
ex_valid  out  1  ID/EX register holds a real instruction
ex_pc  out  32  ID/EX PC
ex_instr  out  32  ID/EX instruction word
ex_imm  out  32  sign-extended immediate for the decoded format
ex_rs1_val  out  32  captured rs1_data
ex_rs2_val  out  32  captured rs2_data
ex_rd  out  5  destination register; 0 if the instruction has no rd

Behaviour:
- Fetch contract: while stall_f=1 in cycle t, pc_in/instr_in are unchanged in cycle t+1. When branch_taken=1 in cycle t, instr_in in cycle t+1 is the instruction at branch_target.
- ID valid: instr_in is valid every cycle with rst=0, including the first cycle after reset, where instr_in is imem[0].
- Reset (clk edge with rst=1):
  - ex_valid=0; ex_pc, ex_instr, ex_imm, ex_rs1_val, ex_rs2_val, ex_rd all 0.
  - Scoreboard cleared.
  - stall_f, branch_taken and branch_target are forced to 0 combinationally while rst=1.
- Scoreboard: shift register of {valid, rd, is_load} entries for the EX and MEM stages (plus WB when REGFILE_BYPASS=0).
  - Shifts every cycle; downstream stages never stall.
  - The entry entering EX is the issued instruction, or a bubble when stalling.
  - rd=x0 is never a hazard.
- Hazard rules, using rs1/rs2 only when the opcode actually reads them:
  - Branch or JALR source matches a valid scoreboard entry in any stage → stall.
  - Any other instruction whose source matches a load in EX → stall (one cycle, load-use).
  - ALU producers in EX are forwarded by EX; no stall.
- Stall cycle:
  - stall_f=1, branch_taken=0.
  - On the edge, ID/EX gets a bubble: ex_valid=0, ex_rd=0; the scoreboard shifts in an invalid entry.
  - The stalled instruction re-evaluates every cycle and issues in the first cycle with no hazard.
- Branch resolution, only in a non-stalled valid cycle; combinational, zero-cycle latency:
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: compare rs1_data and rs2_data, signed or unsigned per funct3. If taken, branch_target = pc_in + immB.
  - JAL: always taken, target = pc_in + immJ.
  - JALR: always taken, target = (rs1_data + immI) & ~1.
  - Not taken: branch_taken=0; branch_target is don't-care, driven pc_in+4.
- All adds are 32-bit with wrap-around (0xFFFFFFFC + 8 = 0x00000004).
- Issue: on a non-stalled edge, the ID/EX register captures pc_in, instr_in, imm, rs1_data, rs2_data and rd. Branches carry rd=0; JAL/JALR carry their rd for the link write.
- Unknown opcode: issued with ex_valid=1, rd=0, never taken; no trap in this block.
- stall_f and branch_taken are never both 1.
- rst asserted mid-stall: the stall is dropped and the scoreboard cleared; the pipeline restarts at pc 0.

Decomposition:
- Shared package (alongside word_t):
  - opcode constants (OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_STORE);
  - funct3 branch codes;
  - typedef sb_entry_t {valid, rd[4:0], is_load};
  - typedef reg_idx_t (5 bits).
- One sub-module: imm_gen (combinational; instr → immI/immS/immB/immU/immJ plus a format select), reused later by EX.

Test Plan:
- Reset, then imem[0] = ADDI x1,x0,5 → first cycle after rst: ex_valid=0 and no stall; next edge ex_valid=1, ex_imm=5, ex_rd=1.
- BEQ x0,x0,+16 at pc 0x20 → same cycle branch_taken=1, branch_target=0x30, stall_f=0; ID/EX ex_rd=0.
- LW x5,0(x2) then ADD x6,x5,x1 → ADD cycle: stall_f=1 for exactly 1 cycle, bubble ex_valid=0; next cycle ADD issues.
- ADDI x3,x0,1 then BNE x3,x0,-8 at pc 0x100 → stall_f=1 for 2 cycles (3 with REGFILE_BYPASS=0); then branch_taken=1, target=0xF8.
- JALR x1,12(x4), x4=0x0FFFFFF7 and no hazard → target=0x10000002 (bit0 cleared); ex_rd=1. With x4=0xFFFFFFF8 and imm=12 → target 0x00000004 (wrap).
- rst pulsed during a branch-dependency stall → all ex_* outputs 0 and stall_f=0 next cycle; a dependency on the pre-reset producer does not stall after reset.
